// File: rtl/inequality_scanner_pkg.sv
// Shared widths and scan state encoding for the inequality scanner slice.
package inequality_scanner_pkg;

    localparam int NUM_W = 4;
    localparam int RES_W = 3;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/inequality_result_table.sv
// 16x3 truth-table register file: synchronous write and clear, asynchronous read.
module inequality_result_table
    import inequality_scanner_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [NUM_W-1:0] waddr,
    input  logic [RES_W-1:0] wdata,
    input  logic [NUM_W-1:0] raddr,
    output logic [RES_W-1:0] rdata
);

    logic [RES_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A read of the entry being written returns the old value this cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/inequality_scanner.sv
// Sweeps NUM 0..15 into the Inequality classifier, records each OUT in a table and tallies OUT bits.
//
// state  | meaning
// IDLE   | waiting for start, num_out held at 0
// DRIVE  | num_out = idx, waiting SETTLE cycles for the classifier to settle
// SAMPLE | capture res_in into table[idx] and the bit tallies
// DONE   | one-cycle completion pulse
module inequality_scanner
    import inequality_scanner_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [NUM_W-1:0] num_out,
    input  logic [RES_W-1:0] res_in,
    output logic             busy,
    output logic             done,
    input  logic [NUM_W-1:0] rd_addr,
    output logic [RES_W-1:0] rd_data,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt0
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [NUM_W-1:0] LAST_IDX    = NUM_W'(DEPTH - 1);

    scan_state_e      state, state_nxt;
    logic [NUM_W-1:0] idx;
    logic [3:0]       settle_cnt;
    logic             table_we;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        table_we  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = DRIVE;
            end
            DRIVE: begin
                busy = 1'b1;
                if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                busy      = 1'b1;
                table_we  = 1'b1;
                state_nxt = (idx == LAST_IDX) ? DONE : DRIVE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            num_out    <= '0;
            cnt2       <= '0;
            cnt1       <= '0;
            cnt0       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        settle_cnt <= '0;
                        num_out    <= '0;
                        cnt2       <= '0;
                        cnt1       <= '0;
                        cnt0       <= '0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    cnt2 <= cnt2 + CNT_W'(res_in[2]);
                    cnt1 <= cnt1 + CNT_W'(res_in[1]);
                    cnt0 <= cnt0 + CNT_W'(res_in[0]);
                    // num_out only moves here, so it is stable across DRIVE and SAMPLE of each idx.
                    if (idx != LAST_IDX) begin
                        idx        <= idx + 1'b1;
                        num_out    <= idx + 1'b1;
                        settle_cnt <= '0;
                    end
                end
                DONE: begin
                    num_out <= '0;
                end
                default: ;
            endcase
        end
    end

    inequality_result_table u_table (
        .clk   (clk),
        .reset (reset),
        .we    (table_we),
        .waddr (idx),
        .wdata (res_in),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
